t05_sram_arbiter: RTL and testbench

- Single-owner arbiter for the shared SRAM port.
- Lets up to NUM_REQ datapath blocks issue one-word read or write transactions through one SRAM controller interface. Requesters include the histogram builder, least-frequency finder, tree builder and codebook generator.
- Grants exactly one requester at a time and latches its command. Drives the SRAM controller through a req/busy handshake, then returns read data with a one-cycle ack.
- Sits between the phase blocks and the SRAM controller in the compression top level.

---
 rtl/t05_arb_pkg.sv | 20 ++
 rtl/t05_arb_picker.sv | 39 +++
 rtl/t05_sram_arbiter.sv | 146 ++++++++++++++
 tb/tb_t05_sram_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t05_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : t05_arb_pkg
// Brief    : Shared types and constants for the SRAM port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package t05_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic MEM_OP_READ  = 1'b0;
    localparam logic MEM_OP_WRITE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/t05_arb_picker.sv
`default_nettype none
// ============================================================================
// Module   : t05_arb_picker
// Brief    : Combinational first-set search over a request vector, starting
//            at a base index and wrapping modulo N.
// Revision : 1.0 - initial release
// ============================================================================
module t05_arb_picker #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] base,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        int cand;
        cand   = 0;
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand = int'(base) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!valid && req[IDX_W'(cand)]) begin
                valid                 = 1'b1;
                idx                   = IDX_W'(cand);
                onehot[IDX_W'(cand)]  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/t05_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : t05_sram_arbiter
// Brief    : Single-owner arbiter granting one requester at a time access to
//            the SRAM controller via a req/busy handshake, with timeout.
//            Optional macro T05_ARB_ROUND_ROBIN_EN selects round-robin
//            arbitration; otherwise fixed priority (index 0 highest).
// Revision : 1.0 - initial release
// ============================================================================
module t05_sram_arbiter
    import t05_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        we_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        ack_o,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      err_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_wdata_o,
    input  logic                      mem_busy_i,
    input  logic [DATA_W-1:0]         mem_rdata_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_first;

    logic [NUM_REQ-1:0] w_win_onehot;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_win_valid;
    logic [IDX_W-1:0]   w_base;

    logic [ADDR_W-1:0] w_addr  [NUM_REQ];
    logic [DATA_W-1:0] w_wdata [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
        assign w_addr[k]  = addr_i[k*ADDR_W +: ADDR_W];
        assign w_wdata[k] = wdata_i[k*DATA_W +: DATA_W];
    end

`ifdef T05_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] r_ptr;

    // Pointer remembers the last winner so the search starts just past it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= IDX_W'(NUM_REQ - 1);
        end else if (r_state == IDLE && w_win_valid) begin
            r_ptr <= w_win_idx;
        end
    end

    assign w_base = (r_ptr == IDX_W'(NUM_REQ - 1)) ? '0 : r_ptr + IDX_W'(1);
`else
    assign w_base = '0;
`endif

    t05_arb_picker #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req    (req_i),
        .base   (w_base),
        .onehot (w_win_onehot),
        .idx    (w_win_idx),
        .valid  (w_win_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_first     <= 1'b0;
            ack_o       <= '0;
            grant_o     <= '0;
            rdata_o     <= '0;
            err_o       <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= MEM_OP_READ;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            mem_req_o <= 1'b0;
            ack_o     <= '0;
            err_o     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_win_valid) begin
                        grant_o     <= w_win_onehot;
                        mem_we_o    <= we_i[w_win_idx];
                        mem_addr_o  <= w_addr[w_win_idx];
                        mem_wdata_o <= w_wdata[w_win_idx];
                        mem_req_o   <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cnt   <= '0;
                    r_first <= 1'b1;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // Controller may only raise busy one cycle after the strobe.
                    if (r_first) begin
                        r_first <= 1'b0;
                    end else if (!mem_busy_i) begin
                        if (mem_we_o != MEM_OP_WRITE) begin
                            rdata_o <= mem_rdata_i;
                        end
                        ack_o   <= grant_o;
                        r_state <= DONE;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                        ack_o   <= grant_o;
                        err_o   <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    grant_o <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_t05_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_t05_sram_arbiter
// Brief    : Directed self-checking bench for t05_sram_arbiter with a small
//            SRAM controller model (3-cycle busy, optional stuck busy).
// Revision : 1.0 - initial release
// ============================================================================
module tb_t05_sram_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_i;
    logic [3:0]   we_i;
    logic [31:0]  addr_i;
    logic [127:0] wdata_i;
    logic [3:0]   ack_o;
    logic [3:0]   grant_o;
    logic [31:0]  rdata_o;
    logic         err_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [7:0]   mem_addr_o;
    logic [31:0]  mem_wdata_o;
    logic         mem_busy_i;
    logic [31:0]  mem_rdata_i;

    t05_sram_arbiter #(
        .NUM_REQ (4),
        .ADDR_W  (8),
        .DATA_W  (32),
        .TIMEOUT (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .ack_o       (ack_o),
        .grant_o     (grant_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_busy_i  (mem_busy_i),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk = ~clk;

    // SRAM controller model: busy for 3 cycles starting the cycle after the strobe.
    logic [31:0] mem [256];
    logic        m_busy;
    logic [1:0]  m_cnt;
    logic [7:0]  m_addr;
    logic        m_we;
    logic [31:0] m_rdata;
    logic        busy_stuck;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy      <= 1'b0;
            m_cnt       <= 2'd0;
            m_addr      <= 8'd0;
            m_we        <= 1'b0;
            m_rdata     <= 32'd0;
            mem[8'h41]  <= 32'h0000_0007;
            mem[8'h1A]  <= 32'h0000_0005;
        end else if (mem_req_o) begin
            m_busy <= 1'b1;
            m_cnt  <= 2'd2;
            m_addr <= mem_addr_o;
            m_we   <= mem_we_o;
            if (mem_we_o) begin
                mem[mem_addr_o] <= mem_wdata_o;
            end
        end else if (m_busy) begin
            if (m_cnt == 2'd0) begin
                m_busy <= 1'b0;
                if (!m_we) begin
                    m_rdata <= mem[m_addr];
                end
            end else begin
                m_cnt <= m_cnt - 2'd1;
            end
        end
    end

    assign mem_busy_i  = m_busy | busy_stuck;
    assign mem_rdata_i = m_rdata;

    // Event bookkeeping sampled at the active edge (pre-update values).
    int         cyc = 0;
    int         n_mreq = 0;
    int         n_ack = 0;
    int         req_cyc = 0;
    int         ack_cyc = 0;
    logic [7:0] last_addr = 8'd0;
    logic       last_we = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_req_o) begin
            n_mreq    <= n_mreq + 1;
            req_cyc   <= cyc;
            last_addr <= mem_addr_o;
            last_we   <= mem_we_o;
        end
        if (ack_o != 4'd0) begin
            n_ack   <= n_ack + 1;
            ack_cyc <= cyc;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic we, input logic [7:0] a, input logic [31:0] d);
        req_i[k]             = 1'b1;
        we_i[k]              = we;
        addr_i[k*8 +: 8]     = a;
        wdata_i[k*32 +: 32]  = d;
    endtask

    // Waits (bounded) for an ack; optionally drops the acked request in the ack cycle.
    task automatic wait_ack(input logic drop, output logic [3:0] a, output logic e);
        a = 4'd0;
        e = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ack_o != 4'd0) begin
                a = ack_o;
                e = err_o;
                if (drop) begin
                    req_i = req_i & ~ack_o;
                end
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] a;
        logic       e;
        int         m0;
        int         a0;
        logic [3:0] first_exp;
        logic [3:0] second_exp;

        req_i      = 4'd0;
        we_i       = 4'd0;
        addr_i     = 32'd0;
        wdata_i    = 128'd0;
        busy_stuck = 1'b0;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_grant",   32'(grant_o),   32'd0);
        chk("reset_ack",     32'(ack_o),     32'd0);
        chk("reset_mem_req", 32'(mem_req_o), 32'd0);
        chk("reset_addr",    32'(mem_addr_o), 32'd0);
        chk("reset_rdata",   rdata_o,        32'd0);
        chk("reset_err",     32'(err_o),     32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single read
        m0 = n_mreq;
        a0 = n_ack;
        set_req(0, 1'b0, 8'h41, 32'd0);
        wait_ack(1'b1, a, e);
        chk("rd_ack",   32'(a),  32'h1);
        chk("rd_err",   32'(e),  32'h0);
        chk("rd_rdata", rdata_o, 32'h0000_0007);
        @(negedge clk);
        chk("rd_addr",    32'(last_addr),  32'h41);
        chk("rd_we",      32'(last_we),    32'h0);
        chk("rd_grant0",  32'(grant_o),    32'd0);
        chk("rd_nreq",    32'(n_mreq - m0), 32'd1);
        chk("rd_nack",    32'(n_ack - a0),  32'd1);
        chk("rd_latency", 32'(ack_cyc - req_cyc), 32'd5);

        // Read-modify-write from requester 0
        set_req(0, 1'b0, 8'h1A, 32'd0);
        wait_ack(1'b1, a, e);
        chk("rmw_rd_ack",   32'(a),  32'h1);
        chk("rmw_rd_rdata", rdata_o, 32'h5);
        @(negedge clk);
        set_req(0, 1'b1, 8'h1A, 32'h6);
        wait_ack(1'b1, a, e);
        chk("rmw_wr_ack",   32'(a),  32'h1);
        chk("rmw_wr_rdata_held", rdata_o, 32'h5);
        @(negedge clk);
        chk("rmw_wr_we",  32'(last_we), 32'h1);
        chk("rmw_mem",    mem[8'h1A],   32'h6);

        // Lone transaction from requester 1 (leaves the round-robin pointer at 1)
        set_req(1, 1'b1, 8'h20, 32'h11);
        wait_ack(1'b1, a, e);
        chk("r1_ack", 32'(a), 32'h2);
        @(negedge clk);

        // Contention between requesters 1 and 3
`ifdef T05_ARB_ROUND_ROBIN_EN
        first_exp  = 4'b1000;
        second_exp = 4'b0010;
`else
        first_exp  = 4'b0010;
        second_exp = 4'b1000;
`endif
        set_req(1, 1'b1, 8'h21, 32'hA1);
        set_req(3, 1'b1, 8'h23, 32'hA3);
        wait_ack(1'b1, a, e);
        chk("cont_first",  32'(a), 32'(first_exp));
        wait_ack(1'b1, a, e);
        chk("cont_second", 32'(a), 32'(second_exp));
        @(negedge clk);
        chk("cont_mem1", mem[8'h21], 32'hA1);
        chk("cont_mem3", mem[8'h23], 32'hA3);

        // Requesters 0 and 2 held continuously for 8 transactions
        set_req(0, 1'b1, 8'h30, 32'hB0);
        set_req(2, 1'b1, 8'h32, 32'hB2);
        for (int i = 0; i < 8; i++) begin
            wait_ack(1'b0, a, e);
`ifdef T05_ARB_ROUND_ROBIN_EN
            chk($sformatf("starve_%0d", i), 32'(a), (i % 2 == 0) ? 32'h4 : 32'h1);
`else
            chk($sformatf("starve_%0d", i), 32'(a), 32'h1);
`endif
        end
        req_i = 4'd0;
        @(negedge clk);

        // Timeout with busy stuck high
        busy_stuck = 1'b1;
        set_req(0, 1'b0, 8'h41, 32'd0);
        wait_ack(1'b1, a, e);
        chk("to_ack", 32'(a), 32'h1);
        chk("to_err", 32'(e), 32'h1);
        @(negedge clk);
        chk("to_latency", 32'(ack_cyc - req_cyc), 32'd12);
        busy_stuck = 1'b0;
        set_req(0, 1'b0, 8'h41, 32'd0);
        wait_ack(1'b1, a, e);
        chk("after_to_ack",   32'(a),  32'h1);
        chk("after_to_err",   32'(e),  32'h0);
        chk("after_to_rdata", rdata_o, 32'h7);
        @(negedge clk);

        // Asynchronous reset in the middle of WAIT
        busy_stuck = 1'b1;
        set_req(0, 1'b0, 8'h41, 32'd0);
        repeat (4) @(negedge clk);
        chk("rst_pre_grant", 32'(grant_o), 32'h1);
        a0 = n_ack;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_grant",   32'(grant_o),   32'd0);
        chk("rst_ack",     32'(ack_o),     32'd0);
        chk("rst_err",     32'(err_o),     32'd0);
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_mem_we",  32'(mem_we_o),  32'd0);
        chk("rst_mem_addr", 32'(mem_addr_o), 32'd0);
        chk("rst_rdata",   rdata_o,        32'd0);
        req_i      = 4'd0;
        busy_stuck = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_no_ack", 32'(n_ack - a0), 32'd0);
        @(negedge clk);
        set_req(2, 1'b0, 8'h41, 32'd0);
        wait_ack(1'b1, a, e);
        chk("post_rst_ack",   32'(a),  32'h4);
        chk("post_rst_err",   32'(e),  32'h0);
        chk("post_rst_rdata", rdata_o, 32'h7);
        @(negedge clk);
        chk("post_rst_grant", 32'(grant_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
